// File: rtl/freq_regulator_gen2.sv
// -----------------------------------------------------------------------------
// freq_regulator_gen2
//
// Purpose:
//   Measures the high time of the pulse input psi in clk cycles and compares
//   it with set_period. After each completed measurement the clock-divider
//   value adjusted_div is stepped up or down (or held inside the deadband) to
//   pull the measured period onto the target. Includes min/max saturation,
//   divider preload, lock detection and overrange flagging.
//
// Optional feature (compile-time macro):
//   PROPORTIONAL_STEP_EN - step = max(1, |err| >> STEP_SHIFT), clamped to
//                          WIDTH bits. When undefined, the step is always 1.
//
// Ports:
//   clk           in   1      system clock, all logic on posedge
//   rst_n         in   1      asynchronous active-low reset
//   en            in   1      regulator enable
//   psi           in   1      measured pulse, synchronous to clk
//   set_period    in   WIDTH  target high time in cycles (sampled at fall)
//   div_load      in   1      one-cycle strobe: force adjusted_div
//   div_load_val  in   WIDTH  preload value, clamped to [DIV_MIN,DIV_MAX]
//   adjusted_div  out  WIDTH  divider value for the clock divider
//   div_valid     out  1      1-cycle pulse on every adjusted_div update
//   locked        out  1      regulator on target
//   overrange     out  1      last measurement saturated the duration counter
//
// Handshake: there is no backpressure. div_valid is a single-cycle
// qualifier; adjusted_div is stable and valid whenever div_valid is high and
// holds its value between updates.
// -----------------------------------------------------------------------------
module freq_regulator_gen2 #(
    parameter int WIDTH      = 8,
    parameter int DIV_INIT   = 127,
    parameter int DIV_MIN    = 1,
    parameter int DIV_MAX    = 255,
    parameter int DEADBAND   = 0,
    parameter int LOCK_COUNT = 4,
    parameter int STEP_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             psi,
    input  logic [WIDTH-1:0] set_period,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_load_val,
    output logic [WIDTH-1:0] adjusted_div,
    output logic             div_valid,
    output logic             locked,
    output logic             overrange
);

`ifdef PROPORTIONAL_STEP_EN
    localparam bit L_PROP = 1'b1;
`else
    localparam bit L_PROP = 1'b0;
`endif

    localparam int LCW = $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH-1:0]        L_INIT_W  = WIDTH'(DIV_INIT);
    localparam logic [WIDTH-1:0]        L_MIN_W   = WIDTH'(DIV_MIN);
    localparam logic [WIDTH-1:0]        L_MAX_W   = WIDTH'(DIV_MAX);
    localparam logic [WIDTH:0]          L_MIN_X   = (WIDTH+1)'(DIV_MIN);
    localparam logic [WIDTH:0]          L_MAX_X   = (WIDTH+1)'(DIV_MAX);
    localparam logic [WIDTH-1:0]        L_DUR_MAX = '1;
    localparam logic [LCW-1:0]          L_LOCK    = LCW'(LOCK_COUNT);
    localparam logic signed [WIDTH+1:0] L_DB_POS  = (WIDTH+2)'(DEADBAND);
    localparam logic signed [WIDTH+1:0] L_DB_NEG  = -((WIDTH+2)'(DEADBAND));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_psi_q;
    logic [WIDTH-1:0]        r_duration;
    logic                    r_ovf;
    logic signed [WIDTH:0]   r_err;
    logic                    r_err_ovf;
    logic [LCW-1:0]          r_lock_cnt;
    logic [WIDTH-1:0]        r_div;
    logic                    r_div_valid;
    logic                    r_locked;
    logic                    r_overrange;

    logic                    w_rise;
    logic                    w_fall;
    logic [WIDTH:0]          w_err_abs;
    logic [WIDTH:0]          w_err_shr;
    logic [WIDTH-1:0]        w_step;
    logic [WIDTH:0]          w_up_sum;
    logic [WIDTH-1:0]        w_up;
    logic [WIDTH:0]          w_dn_lim;
    logic [WIDTH-1:0]        w_dn;
    logic signed [WIDTH+1:0] w_err_ext;
    logic                    w_above;
    logic                    w_below;
    logic [WIDTH-1:0]        w_load_val;
    logic [LCW-1:0]          w_lock_inc;

    assign w_rise = ~r_psi_q & psi;
    assign w_fall = r_psi_q & ~psi;

    // |err| never reaches 2^WIDTH since both operands are WIDTH-bit unsigned.
    assign w_err_abs = r_err[WIDTH] ? WIDTH'(0) - r_err : r_err;
    assign w_err_shr = w_err_abs >> STEP_SHIFT;

    always_comb begin
        w_step = {{(WIDTH-1){1'b0}}, 1'b1};
        if (L_PROP && (w_err_shr != '0)) begin
            w_step = w_err_shr[WIDTH] ? '1 : w_err_shr[WIDTH-1:0];
        end
    end

    // Step arithmetic is carried one bit wider so neither direction wraps.
    assign w_up_sum = {1'b0, r_div} + {1'b0, w_step};
    assign w_up     = (w_up_sum > L_MAX_X) ? L_MAX_W : w_up_sum[WIDTH-1:0];
    assign w_dn_lim = {1'b0, w_step} + L_MIN_X;
    assign w_dn     = ({1'b0, r_div} < w_dn_lim) ? L_MIN_W : r_div - w_step;

    assign w_err_ext = {r_err[WIDTH], r_err};
    assign w_above   = w_err_ext > L_DB_POS;
    assign w_below   = w_err_ext < L_DB_NEG;

    assign w_load_val = (div_load_val < L_MIN_W) ? L_MIN_W :
                        (div_load_val > L_MAX_W) ? L_MAX_W : div_load_val;

    assign w_lock_inc = (r_lock_cnt == L_LOCK) ? r_lock_cnt : r_lock_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_psi_q     <= 1'b0;
            r_duration  <= '0;
            r_ovf       <= 1'b0;
            r_err       <= '0;
            r_err_ovf   <= 1'b0;
            r_lock_cnt  <= '0;
            r_div       <= L_INIT_W;
            r_div_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_overrange <= 1'b0;
        end else begin
            r_psi_q     <= psi;
            r_div_valid <= 1'b0;

            // Duration counter runs on psi alone; the FSM decides whether
            // the result is used.
            if (w_rise) begin
                r_duration <= {{(WIDTH-1){1'b0}}, 1'b1};
                r_ovf      <= 1'b0;
            end else if (psi) begin
                if (r_duration == L_DUR_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_duration <= r_duration + 1'b1;
                end
            end

            if (div_load) begin
                r_div       <= w_load_val;
                r_div_valid <= 1'b1;
                r_lock_cnt  <= '0;
                r_locked    <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (en && w_rise) r_state <= S_MEASURE;
                end
                S_MEASURE: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (w_fall) begin
                        r_state   <= S_UPDATE;
                        r_err     <= $signed({1'b0, r_duration}) - $signed({1'b0, set_period});
                        r_err_ovf <= r_ovf;
                    end
                end
                S_UPDATE: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= w_rise ? S_MEASURE : S_IDLE;
                        // A simultaneous preload discards this measurement.
                        if (!div_load) begin
                            r_div_valid <= 1'b1;
                            r_overrange <= r_err_ovf;
                            if (r_err_ovf || w_above) begin
                                r_div      <= w_up;
                                r_lock_cnt <= '0;
                                r_locked   <= 1'b0;
                            end else if (w_below) begin
                                r_div      <= w_dn;
                                r_lock_cnt <= '0;
                                r_locked   <= 1'b0;
                            end else begin
                                r_lock_cnt <= w_lock_inc;
                                r_locked   <= (w_lock_inc == L_LOCK);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign adjusted_div = r_div;
    assign div_valid    = r_div_valid;
    assign locked       = r_locked;
    assign overrange    = r_overrange;

endmodule

// File: tb/tb_freq_regulator_gen2.sv
// -----------------------------------------------------------------------------
// tb_freq_regulator_gen2
//   Table of directed pulses with hand-computed expected values, a few
//   hand-written multi-cycle sequences (preload vs update, reset mid-pulse,
//   enable gating), then randomized pulses checked by a scoreboard fed from
//   an arithmetic model of the regulator.
// -----------------------------------------------------------------------------
module tb_freq_regulator_gen2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       psi;
    logic [7:0] set_period;
    logic       div_load;
    logic [7:0] div_load_val;
    logic [7:0] adjusted_div;
    logic       div_valid;
    logic       locked;
    logic       overrange;

    freq_regulator_gen2 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .psi          (psi),
        .set_period   (set_period),
        .div_load     (div_load),
        .div_load_val (div_load_val),
        .adjusted_div (adjusted_div),
        .div_valid    (div_valid),
        .locked       (locked),
        .overrange    (overrange)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected {overrange, locked, adjusted_div} for every div_valid pulse.
    logic [9:0] exp_q[$];
    int m_div    = 127;
    int m_lock   = 0;
    bit m_locked = 1'b0;
    bit m_ovr    = 1'b0;

    function automatic int m_step(input int err);
`ifdef PROPORTIONAL_STEP_EN
        int a;
        a = (err < 0) ? -err : err;
        a = a / 4;
        if (a < 1) a = 1;
        if (a > 255) a = 255;
        return a;
`else
        return 1;
`endif
    endfunction

    function automatic void m_push();
        logic [9:0] e;
        e = {m_ovr, m_locked, 8'(m_div)};
        exp_q.push_back(e);
    endfunction

    function automatic void m_pulse(input int len, input int set);
        int  dur;
        int  err;
        bit  ovf;
        ovf = (len > 255);
        dur = ovf ? 255 : len;
        err = dur - set;
        if (ovf || err > 0) begin
            m_div = m_div + m_step(err);
            if (m_div > 255) m_div = 255;
            m_lock = 0; m_locked = 1'b0;
        end else if (err < 0) begin
            m_div = m_div - m_step(err);
            if (m_div < 1) m_div = 1;
            m_lock = 0; m_locked = 1'b0;
        end else begin
            if (m_lock < 4) m_lock++;
            m_locked = (m_lock == 4);
        end
        m_ovr = ovf;
        m_push();
    endfunction

    function automatic void m_load(input int val);
        m_div = (val < 1) ? 1 : (val > 255) ? 255 : val;
        m_lock = 0; m_locked = 1'b0;
        m_push();
    endfunction

    function automatic void m_reset();
        m_div = 127; m_lock = 0; m_locked = 1'b0; m_ovr = 1'b0;
        exp_q.delete();
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && div_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_update: got div_valid with div 0x%0h, expected no update (t=%0t)",
                         adjusted_div, $time);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("sb_update", {22'd0, overrange, locked, adjusted_div}, {22'd0, e});
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        int set;
        int hi;
        int lo;
        int exp_div;
        bit exp_lk;
        bit exp_ov;
    } vec_t;

    vec_t tbl[13];
    int   pre_hi   = 0;
    int   prev_exp = 127;

    // Applies one pulse and checks the two-edge update latency. lo==1 leaves
    // psi rising again in the UPDATE cycle so the next entry is captured
    // back-to-back.
    task automatic run_vec(input vec_t v);
        set_period = 8'(v.set);
        psi = 1'b1;
        repeat (v.hi - pre_hi) @(negedge clk);
        psi = 1'b0;
        m_pulse(v.hi, v.set);
        @(negedge clk);
        chk("pre_update_div", adjusted_div, prev_exp);
        chk("pre_update_valid", div_valid, 0);
        if (v.lo == 1) psi = 1'b1;
        @(negedge clk);
        chk("update_div", adjusted_div, v.exp_div);
        chk("update_valid", div_valid, 1);
        chk("update_locked", locked, v.exp_lk);
        chk("update_overrange", overrange, v.exp_ov);
        prev_exp = v.exp_div;
        if (v.lo == 1) begin
            pre_hi = 1;
        end else begin
            pre_hi = 0;
            repeat (v.lo - 2) @(negedge clk);
        end
    endtask

    task automatic load_pulse(input int val);
        div_load     = 1'b1;
        div_load_val = 8'(val);
        m_load(val);
        @(negedge clk);
        div_load = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t v;
        int   s, h, l, ld;

        rst_n = 1'b0; en = 1'b1; psi = 1'b0;
        set_period = 8'd10; div_load = 1'b0; div_load_val = 8'd0;

`ifdef PROPORTIONAL_STEP_EN
        tbl[0]  = '{10, 12, 4, 128, 1'b0, 1'b0};
        tbl[1]  = '{10,  8, 1, 127, 1'b0, 1'b0};
        tbl[2]  = '{10,  8, 4, 126, 1'b0, 1'b0};
        tbl[3]  = '{10, 10, 3, 126, 1'b0, 1'b0};
        tbl[4]  = '{10, 10, 3, 126, 1'b0, 1'b0};
        tbl[5]  = '{10, 10, 3, 126, 1'b0, 1'b0};
        tbl[6]  = '{10, 10, 3, 126, 1'b1, 1'b0};
        tbl[7]  = '{10, 10, 3, 126, 1'b1, 1'b0};
        tbl[8]  = '{10, 11, 3, 127, 1'b0, 1'b0};
        tbl[9]  = '{10, 300, 3, 188, 1'b0, 1'b1};
        tbl[10] = '{0,   5, 3, 189, 1'b0, 1'b0};
        tbl[11] = '{200, 250, 3, 201, 1'b0, 1'b0};
        tbl[12] = '{10, 50, 3, 211, 1'b0, 1'b0};
`else
        tbl[0]  = '{10, 12, 4, 128, 1'b0, 1'b0};
        tbl[1]  = '{10,  8, 1, 127, 1'b0, 1'b0};
        tbl[2]  = '{10,  8, 4, 126, 1'b0, 1'b0};
        tbl[3]  = '{10, 10, 3, 126, 1'b0, 1'b0};
        tbl[4]  = '{10, 10, 3, 126, 1'b0, 1'b0};
        tbl[5]  = '{10, 10, 3, 126, 1'b0, 1'b0};
        tbl[6]  = '{10, 10, 3, 126, 1'b1, 1'b0};
        tbl[7]  = '{10, 10, 3, 126, 1'b1, 1'b0};
        tbl[8]  = '{10, 11, 3, 127, 1'b0, 1'b0};
        tbl[9]  = '{10, 300, 3, 128, 1'b0, 1'b1};
        tbl[10] = '{0,   5, 3, 129, 1'b0, 1'b0};
        tbl[11] = '{200, 250, 3, 130, 1'b0, 1'b0};
        tbl[12] = '{10, 50, 3, 131, 1'b0, 1'b0};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_div", adjusted_div, 127);
        chk("reset_valid", div_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_overrange", overrange, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // Preload coincident with the UPDATE cycle wins; measurement dropped.
        set_period = 8'd10;
        psi = 1'b1;
        repeat (12) @(negedge clk);
        psi = 1'b0;
        @(negedge clk);
        load_pulse(255);
        chk("load_win_div", adjusted_div, 255);
        chk("load_win_valid", div_valid, 1);
        chk("load_win_locked", locked, 0);
        @(negedge clk);
        chk("load_win_no_second_valid", div_valid, 0);
        chk("load_win_div_hold", adjusted_div, 255);
        repeat (2) @(negedge clk);
        prev_exp = 255;
        v = '{10, 20, 3, 255, 1'b0, 1'b0};
        run_vec(v);

        // Preload below DIV_MIN clamps, then a short pulse cannot go lower.
        load_pulse(0);
        chk("load_clamp_div", adjusted_div, 1);
        chk("load_clamp_valid", div_valid, 1);
        repeat (2) @(negedge clk);
        prev_exp = 1;
        v = '{10, 5, 3, 1, 1'b0, 1'b0};
        run_vec(v);
`ifdef PROPORTIONAL_STEP_EN
        v = '{10, 300, 3, 62, 1'b0, 1'b1};
`else
        v = '{10, 300, 3, 2, 1'b0, 1'b1};
`endif
        run_vec(v);

        // Reset asserted mid-pulse clears outputs immediately.
        psi = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_div", adjusted_div, 127);
        chk("midreset_valid", div_valid, 0);
        chk("midreset_locked", locked, 0);
        chk("midreset_overrange", overrange, 0);
        m_reset();
        @(negedge clk);
        psi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_no_update", adjusted_div, 127);

        // en dropped mid-measurement aborts it.
        set_period = 8'd10;
        psi = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        psi = 1'b0;
        repeat (5) @(negedge clk);
        chk("en_abort_div", adjusted_div, 127);

        // Pulse already high when en rises is ignored.
        en = 1'b0;
        psi = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (20) @(negedge clk);
        psi = 1'b0;
        repeat (5) @(negedge clk);
        chk("en_late_div", adjusted_div, 127);
        prev_exp = 127;
        pre_hi = 0;

        // Randomized pulses against the model.
        for (int i = 0; i < 60; i++) begin
            s = $urandom_range(0, 40);
            case ($urandom_range(0, 3))
                0:       h = s + $urandom_range(0, 2) - 1;
                1:       h = s;
                default: h = $urandom_range(1, 60);
            endcase
            if (i % 15 == 7) h = $urandom_range(256, 300);
            if (h < 1) h = 1;
            l = $urandom_range(1, 5);
            set_period = 8'(s);
            psi = 1'b1;
            repeat (h) @(negedge clk);
            psi = 1'b0;
            m_pulse(h, s);
            repeat (l) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                repeat (3) @(negedge clk);
                ld = $urandom_range(0, 255);
                load_pulse(ld);
            end
        end
        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
